pht_update_scheduler: RTL

// Owns the single-port 2-bit-counter PHT RAM and shares it between fetch-stage predictor lookups and ID-stage

---
 rtl/pht_update_scheduler_pkg.sv | 24 ++
 rtl/pht_update_scheduler_fifo.sv | 52 +++++
 rtl/pht_update_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pht_update_scheduler_pkg.sv
// PHT scheduler shared constants: counter encodings, FSM state codes
// and the saturating 2-bit counter step.
package pht_update_scheduler_pkg;

   localparam logic [1:0] PHT_CNT_WNT = 2'b01;
   localparam logic [1:0] PHT_CNT_SAT = 2'b11;

   localparam logic [1:0] PHS_INIT = 2'd0;
   localparam logic [1:0] PHS_IDLE = 2'd1;
   localparam logic [1:0] PHS_RD   = 2'd2;
   localparam logic [1:0] PHS_WR   = 2'd3;

   function automatic logic [1:0] pht_cnt_next(
      input logic [1:0] cnt,
      input logic       taken
   );
      if (taken)
         return (cnt == PHT_CNT_SAT) ? PHT_CNT_SAT
                                     : cnt + 2'd1;
      else
         return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/pht_update_scheduler_fifo.sv
// Resolved-branch update queue: {idx, taken} entries, pointer and
// count based, head visible combinationally.
module pht_update_scheduler_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/pht_update_scheduler.sv
// Single-port PHT RAM arbiter: lookups own the port, queued training
// updates retire as read-modify-write in idle cycles after a table sweep.
module pht_update_scheduler #(
   parameter int IDX_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             lookup_req,
   input  logic [IDX_W-1:0] lookup_idx,
   output logic             lookup_dir,
   input  logic             upd_valid,
   output logic             upd_ready,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   output logic             ram_en,
   output logic             ram_we,
   output logic [IDX_W-1:0] ram_addr,
   output logic [1:0]       ram_wdata,
   input  logic [1:0]       ram_rdata,
   output logic             init_done,
   output logic             busy
);

   import pht_update_scheduler_pkg::*;

   logic [1:0]       state;
   logic [IDX_W-1:0] sweep_ptr;
   logic [1:0]       cnt_q;
   logic             lookup_q;

   logic [IDX_W:0]   head;
   logic [IDX_W-1:0] head_idx;
   logic             head_taken;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   pht_update_scheduler_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (IDX_W + 1)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .din    ({upd_idx, upd_taken}),
      .pop    (pop),
      .head   (head),
      .full   (full),
      .empty  (empty)
   );

   assign head_idx   = head[IDX_W:1];
   assign head_taken = head[0];

   assign init_done  = (state != PHS_INIT);
   assign upd_ready  = init_done && !full;
   assign push       = upd_valid && upd_ready;
   assign pop        = (state == PHS_WR) && !lookup_req;
   assign busy       = (state != PHS_IDLE) || !empty;
   assign lookup_dir = lookup_q ? ram_rdata[1] : 1'b0;

   // Head stays queued until its write lands, so a following
   // same-index read always observes it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= PHS_INIT;
         sweep_ptr <= '0;
         cnt_q     <= '0;
         lookup_q  <= 1'b0;
      end else begin
         lookup_q <= lookup_req;
         unique case (state)
            PHS_INIT: begin
               if (!lookup_req) begin
                  sweep_ptr <= sweep_ptr + 1'b1;
                  if (&sweep_ptr)
                     state <= PHS_IDLE;
               end
            end
            PHS_IDLE: begin
               if (!empty && !lookup_req)
                  state <= PHS_RD;
            end
            PHS_RD: begin
               cnt_q <= pht_cnt_next(ram_rdata, head_taken);
               state <= PHS_WR;
            end
            PHS_WR: begin
               if (!lookup_req)
                  state <= PHS_IDLE;
            end
            default: state <= PHS_INIT;
         endcase
      end
   end

   // Port mux; reset gating lets an in-flight write die immediately.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (resetn) begin
         if (lookup_req) begin
            ram_en   = 1'b1;
            ram_addr = lookup_idx;
         end else begin
            unique case (state)
               PHS_INIT: begin
                  ram_en    = 1'b1;
                  ram_we    = 1'b1;
                  ram_addr  = sweep_ptr;
                  ram_wdata = PHT_CNT_WNT;
               end
               PHS_IDLE: begin
                  if (!empty) begin
                     ram_en   = 1'b1;
                     ram_addr = head_idx;
                  end
               end
               PHS_WR: begin
                  ram_en    = 1'b1;
                  ram_we    = 1'b1;
                  ram_addr  = head_idx;
                  ram_wdata = cnt_q;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
